servo_pwm_decoder: RTL and testbench
====================================

// Module: servo_pwm_decoder
// PURPOSE
//  Receive side of the servo PWM link. Measures the high time and period of a
//  servo PWM waveform and classifies the pulse width into one of four position
//  codes: ASCII '1'..'4' (0x31..0x34), the same command set the PWM generator accepts.
//  Used for loopback checking of the generator, or as a command receiver from an
//  external RC/servo source.
// PARAMETERS
//  CNT_W    21         width of the width/period counters
//  S0       124_000    nominal high width, position '1' (clk cycles)
//  S1       90_000     nominal high width, position '2'
//  S2       55_000     nominal high width, position '3'
//  S3       20_000     nominal high width, position '4'
//  TOL      5_000      classification tolerance (+/- cycles)
//  TIMEOUT  1_200_000  cycles with no edge before the signal is declared lost
//  GLT_LEN  4          glitch-filter stability length (only with the macro)
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      asynchronous reset, active low
//  pwm_in       in   1      asynchronous servo PWM input
//  width        out  CNT_W  last measured high width (cycles)
//  period       out  CNT_W  last rise-to-rise period (cycles)
//  meas_valid   out  1      1-cycle strobe: width updated
//  pos_code     out  8      last classified code, 0x31..0x34
//  pos_valid    out  1      1-cycle strobe: pulse matched a position
//  pos_onehot   out  4      one-hot of current position (bit0 = '1'); 0 = none
//  err_unknown  out  1      1-cycle strobe: pulse matched no position
//  signal_lost  out  1      level: TIMEOUT expired with no edge
// BEHAVIOUR
//  - Reset: all outputs 0. pos_code = 0x00. FSM = IDLE. Counters = 0.
//  - Input path: 2-FF synchronizer, then optional filter, then filt level,
//    then rise/fall strobes (1 cycle).
//  - FSM
//    IDLE   : wait for filt == 0 (discard partial pulse), then go to WAIT_R.
//    WAIT_R : on rise, go to HIGH. wcnt = 1. pcnt = 1.
//    HIGH   : wcnt++ each cycle filt = 1.
//             On fall: width <= wcnt, go to LOW, and on the next cycle classify.
//    LOW    : pcnt continues. On rise: period <= pcnt, wcnt = 1, pcnt = 1,
//             go to HIGH.
//  - pcnt runs from a rise to the next rise. period updates only after two rises
//    have been seen since IDLE or lost.
//  - Counters saturate at 2^CNT_W-1 and never wrap.
//  - Classification, one cycle after the fall:
//    - meas_valid = 1.
//    - If |width - Sx| <= TOL for some x (first match in order S0..S3):
//      pos_valid = 1, pos_code = 0x31+x, pos_onehot = 1<<x.
//    - Otherwise: err_unknown = 1, and pos_code/pos_onehot hold.
//    - Compare uses CNT_W+1-bit signed difference.
//  - Timeout: an edge-free counter resets on every rise/fall. At TIMEOUT:
//    signal_lost = 1, pos_onehot = 0, FSM = IDLE. pos_code holds.
//    signal_lost clears on the next pos_valid.
//  - Reset mid-pulse: everything returns to reset values. The first pulse is
//    measured only after a low is seen.
//  - The rise and timeout expiry in the same cycle: the rise wins and the timeout
//    counter clears.
// CONFIGURATION
//  - PWM_GLITCH_FILTER_EN defined: filt changes only after the synced input holds
//    its new level for GLT_LEN consecutive cycles. Pulses shorter than GLT_LEN are
//    ignored. Both edges are delayed by GLT_LEN, so width is unchanged.
//  - Undefined: filt = synced input. Edge latency is 2 cycles.
// STRUCTURE
//  - Package servo_pwm_pkg: S0..S3, PERIOD (1_000_000), ASCII_POS1..4
//    (0x31..0x34), the FSM state enum, CNT_W. Shared with the PWM generator.
//  - Sub-module pwm_edge_filter: synchronizer, optional glitch filter, and
//    rise/fall strobes.
// TESTING
//  1. Reset, then pwm_in low for 10 cycles -> all outputs 0, FSM in WAIT_R.
//  2. Period 1_000_000, high 124_000 -> width = 124_000, pos_code = 0x31,
//     pos_onehot = 0001, pos_valid 1 cycle. Second pulse -> period = 1_000_000.
//  3. High 57_000 -> pos_code = 0x33 (within TOL of S2).
//     Then high 70_000 -> err_unknown, pos_code stays 0x33.
//  4. pwm_in stuck high for 1_200_000 cycles -> signal_lost = 1, pos_onehot = 0.
//     Next valid 20_000 pulse -> 0x34 and signal_lost = 0.
//  5. Macro on: a 2-cycle low glitch inside a 90_000 high -> one pulse,
//     width 90_000, code 0x32. Macro off -> two short pulses, err_unknown x2.
//  6. rst_n asserted mid-high -> outputs 0. Release with pwm_in high -> no
//     measurement until the following full pulse.

Source files
------------

// File: rtl/servo_pwm_decoder_pkg.sv
// servo_pwm_pkg: constants and types shared by the servo PWM generator and
// decoder. Nominal pulse widths and the frame period are given in clk cycles.
// The ASCII position codes are the command set the generator accepts.
package servo_pwm_pkg;
  localparam int CNT_W  = 21;
  localparam int S0     = 124_000;
  localparam int S1     = 90_000;
  localparam int S2     = 55_000;
  localparam int S3     = 20_000;
  localparam int PERIOD = 1_000_000;

  localparam logic [7:0] ASCII_POS1 = 8'h31;
  localparam logic [7:0] ASCII_POS2 = 8'h32;
  localparam logic [7:0] ASCII_POS3 = 8'h33;
  localparam logic [7:0] ASCII_POS4 = 8'h34;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // discard any partial pulse until the line is low
    ST_WAIT_R = 2'd1,  // armed, waiting for the first rise
    ST_HIGH   = 2'd2,  // measuring high time
    ST_LOW    = 2'd3   // low part of the frame, period still running
  } pwm_state_t;
endpackage

// File: rtl/servo_pwm_decoder_if.sv
// servo_pwm_decoder_if: PWM input plus the measurement/classification results.
//   master : drives pwm_in, observes results (bench / consumer side)
//   slave  : the decoder (samples pwm_in, drives results)
// Signals: pwm_in, width[CNT_W], period[CNT_W], meas_valid, pos_code[8],
//          pos_valid, pos_onehot[4], err_unknown, signal_lost.
interface servo_pwm_decoder_if #(parameter int CNT_W = servo_pwm_pkg::CNT_W);
  logic             pwm_in;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic [7:0]       pos_code;
  logic             pos_valid;
  logic [3:0]       pos_onehot;
  logic             err_unknown;
  logic             signal_lost;

  modport master (output pwm_in,
                  input  width, period, meas_valid, pos_code, pos_valid,
                         pos_onehot, err_unknown, signal_lost);
  modport slave  (input  pwm_in,
                  output width, period, meas_valid, pos_code, pos_valid,
                         pos_onehot, err_unknown, signal_lost);
endinterface

// File: rtl/servo_pwm_decoder_edge.sv
// pwm_edge_filter: 2-FF synchronizer for the asynchronous PWM input, optional
// glitch filter, and 1-cycle rise/fall strobes of the filtered level.
// Macro PWM_GLITCH_FILTER_EN: filt follows the synced level only after it has
// held a new value for GLT_LEN consecutive cycles (both edges delayed equally).
// Ports: clk, rst_n (async low), pwm_in -> filt, rise, fall, ready.
// ready rises once the pipeline holds real input samples, so a reset-value low
// is never mistaken for a genuine low on the line.
module pwm_edge_filter #(
  parameter int GLT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic filt,
  output logic rise,
  output logic fall,
  output logic ready
);
`ifdef PWM_GLITCH_FILTER_EN
  localparam bit GLT_ON = 1'b1;
`else
  localparam bit GLT_ON = 1'b0;
`endif
  localparam int SETTLE = 3 + (GLT_ON ? GLT_LEN : 0);

  logic       s1, s2, filt_q;
  logic [7:0] stl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      filt_q <= 1'b0;
      stl    <= '0;
    end else begin
      s1     <= pwm_in;
      s2     <= s1;
      filt_q <= filt;
      if (stl != 8'(SETTLE)) stl <= stl + 8'd1;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  logic       filt_r;
  logic [7:0] gcnt;

  // Count consecutive cycles the synced level disagrees with filt; any return
  // to agreement restarts the count, which swallows short glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_r <= 1'b0;
      gcnt   <= '0;
    end else if (s2 == filt_r) begin
      gcnt <= '0;
    end else if (gcnt == 8'(GLT_LEN - 1)) begin
      filt_r <= s2;
      gcnt   <= '0;
    end else begin
      gcnt <= gcnt + 8'd1;
    end
  end
  assign filt = filt_r;
`else
  assign filt = s2;
`endif

  assign ready = (stl == 8'(SETTLE));
  assign rise  = filt & ~filt_q;
  assign fall  = ~filt & filt_q;
endmodule

// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures high time and rise-to-rise period of a servo PWM
// input and classifies the width into position codes '1'..'4' (0x31..0x34).
// Ports: clk, rst_n (async low), bus (servo_pwm_decoder_if.slave):
//   pwm_in in; width/period, meas_valid, pos_code, pos_valid, pos_onehot,
//   err_unknown, signal_lost out.
// Macro PWM_GLITCH_FILTER_EN enables the input glitch filter (see edge filter).
module servo_pwm_decoder #(
  parameter int CNT_W   = servo_pwm_pkg::CNT_W,
  parameter int S0      = servo_pwm_pkg::S0,
  parameter int S1      = servo_pwm_pkg::S1,
  parameter int S2      = servo_pwm_pkg::S2,
  parameter int S3      = servo_pwm_pkg::S3,
  parameter int TOL     = 5_000,
  parameter int TIMEOUT = 1_200_000,
  parameter int GLT_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  servo_pwm_decoder_if.slave   bus
);
  import servo_pwm_pkg::*;

  localparam int                 TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CMAX  = '1;
  localparam logic signed [CNT_W:0] TOL_V = (CNT_W+1)'(TOL);
  localparam int                 SX [4] = '{S0, S1, S2, S3};

  logic filt, rise, fall, ready;

  pwm_edge_filter #(.GLT_LEN(GLT_LEN)) u_edge (
    .clk(clk), .rst_n(rst_n), .pwm_in(bus.pwm_in),
    .filt(filt), .rise(rise), .fall(fall), .ready(ready)
  );

  pwm_state_t       state;
  logic [CNT_W-1:0] wcnt, pcnt, width_r, period_r;
  logic [TO_W-1:0]  tcnt;
  logic             cls_pend, meas_valid_r, pos_valid_r, err_unknown_r, lost_r;
  logic [7:0]       pos_code_r;
  logic [3:0]       onehot_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  // Timeout fires exactly once, on the TIMEOUT-th edge-free cycle; an edge in
  // that same cycle clears the counter instead.
  logic edge_any, expire;
  assign edge_any = rise | fall;
  assign expire   = !edge_any && (tcnt == TO_W'(TIMEOUT - 1));

  // Signed CNT_W+1-bit distance to each nominal width; lowest index wins.
  logic signed [CNT_W:0] diff, mag;
  logic                  hit;
  logic [1:0]            hit_idx;
  always_comb begin
    diff    = '0;
    mag     = '0;
    hit     = 1'b0;
    hit_idx = '0;
    for (int x = 3; x >= 0; x--) begin
      diff = $signed({1'b0, width_r}) - $signed((CNT_W+1)'(SX[x]));
      mag  = diff[CNT_W] ? -diff : diff;
      if (mag <= TOL_V) begin
        hit     = 1'b1;
        hit_idx = 2'(x);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wcnt          <= '0;
      pcnt          <= '0;
      tcnt          <= '0;
      width_r       <= '0;
      period_r      <= '0;
      cls_pend      <= 1'b0;
      meas_valid_r  <= 1'b0;
      pos_valid_r   <= 1'b0;
      err_unknown_r <= 1'b0;
      lost_r        <= 1'b0;
      pos_code_r    <= 8'h00;
      onehot_r      <= 4'b0000;
    end else begin
      meas_valid_r  <= 1'b0;
      pos_valid_r   <= 1'b0;
      err_unknown_r <= 1'b0;
      cls_pend      <= 1'b0;

      if (edge_any)                  tcnt <= '0;
      else if (tcnt != TO_W'(TIMEOUT)) tcnt <= tcnt + 1'b1;

      case (state)
        ST_IDLE:   if (ready && !filt) state <= ST_WAIT_R;
        ST_WAIT_R: if (rise) begin
                     wcnt  <= CNT_W'(1);
                     pcnt  <= CNT_W'(1);
                     state <= ST_HIGH;
                   end
        ST_HIGH: begin
          pcnt <= sat_inc(pcnt);
          if (fall) begin
            width_r  <= wcnt;
            cls_pend <= 1'b1;
            state    <= ST_LOW;
          end else begin
            wcnt <= sat_inc(wcnt);
          end
        end
        ST_LOW: begin
          if (rise) begin
            period_r <= pcnt;
            wcnt     <= CNT_W'(1);
            pcnt     <= CNT_W'(1);
            state    <= ST_HIGH;
          end else begin
            pcnt <= sat_inc(pcnt);
          end
        end
        default: state <= ST_IDLE;
      endcase

      // width_r was loaded on the fall; classify it one cycle later.
      if (cls_pend) begin
        meas_valid_r <= 1'b1;
        if (hit) begin
          pos_valid_r <= 1'b1;
          pos_code_r  <= ASCII_POS1 + {6'd0, hit_idx};
          onehot_r    <= 4'b0001 << hit_idx;
          lost_r      <= 1'b0;
        end else begin
          err_unknown_r <= 1'b1;
        end
      end

      if (expire) begin
        lost_r   <= 1'b1;
        onehot_r <= 4'b0000;
        state    <= ST_IDLE;
      end
    end
  end

  assign bus.width       = width_r;
  assign bus.period      = period_r;
  assign bus.meas_valid  = meas_valid_r;
  assign bus.pos_code    = pos_code_r;
  assign bus.pos_valid   = pos_valid_r;
  assign bus.pos_onehot  = onehot_r;
  assign bus.err_unknown = err_unknown_r;
  assign bus.signal_lost = lost_r;
endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with widths scaled down by 1000
// (S0..S3 = 124/90/55/20, TOL 5, period 1000, TIMEOUT 1200).
module tb_servo_pwm_decoder;
  import servo_pwm_pkg::*;

  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  servo_pwm_decoder_if #(.CNT_W(CW)) bus ();

  servo_pwm_decoder #(
    .CNT_W(CW), .S0(124), .S1(90), .S2(55), .S3(20),
    .TOL(5), .TIMEOUT(1200), .GLT_LEN(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0, errors = 0;
  int n_meas = 0, n_pos = 0, n_err = 0;
  int em = 0, ep = 0, ee = 0;

  // Strobe counters: a strobe held for two cycles shows up as an extra count.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.meas_valid)  n_meas++;
      if (bus.pos_valid)   n_pos++;
      if (bus.err_unknown) n_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int per);
    bus.pwm_in = 1'b1;
    cyc(hi);
    bus.pwm_in = 1'b0;
    cyc(per - hi);
  endtask

  initial begin
    bus.pwm_in = 1'b0;
    rst_n = 1'b0;
    cyc(3);
    chk("rst_width",  32'(bus.width), 0);
    chk("rst_period", 32'(bus.period), 0);
    chk("rst_code",   32'(bus.pos_code), 0);
    chk("rst_onehot", 32'(bus.pos_onehot), 0);
    chk("rst_lost",   32'(bus.signal_lost), 0);
    rst_n = 1'b1;
    cyc(10);
    chk("t1_state",   32'(dut.state), 32'(ST_WAIT_R));
    chk("t1_meas",    32'(n_meas), 0);

    // nominal S0 pulse, then a second one to get a period
    pulse(124, 1000);
    em++; ep++;
    chk("t2_width",   32'(bus.width), 124);
    chk("t2_code",    32'(bus.pos_code), 32'h31);
    chk("t2_onehot",  32'(bus.pos_onehot), 32'b0001);
    chk("t2_pos_cnt", 32'(n_pos), 32'(ep));
    chk("t2_meas",    32'(n_meas), 32'(em));
    chk("t2_period0", 32'(bus.period), 0);
    pulse(124, 1000);
    em++; ep++;
    chk("t2_period",  32'(bus.period), 1000);
    chk("t2_pos_cnt2", 32'(n_pos), 32'(ep));

    // tolerance edges
    pulse(129, 1000);
    em++; ep++;
    chk("tol_s0_hi",  32'(bus.pos_code), 32'h31);
    chk("tol_s0_cnt", 32'(n_pos), 32'(ep));
    pulse(85, 1000);
    em++; ep++;
    chk("tol_s1_lo",  32'(bus.pos_code), 32'h32);
    chk("tol_s1_oh",  32'(bus.pos_onehot), 32'b0010);
    pulse(96, 1000);
    em++; ee++;
    chk("tol_out_err",  32'(n_err), 32'(ee));
    chk("tol_out_code", 32'(bus.pos_code), 32'h32);
    chk("tol_out_w",    32'(bus.width), 96);

    // S2 within tolerance, then unmatched width
    pulse(57, 1000);
    em++; ep++;
    chk("t3_code",   32'(bus.pos_code), 32'h33);
    chk("t3_onehot", 32'(bus.pos_onehot), 32'b0100);
    pulse(70, 1000);
    em++; ee++;
    chk("t3_err",    32'(n_err), 32'(ee));
    chk("t3_hold",   32'(bus.pos_code), 32'h33);
    chk("t3_ohhold", 32'(bus.pos_onehot), 32'b0100);
    chk("t3_width",  32'(bus.width), 70);

    // stuck high -> lost
    bus.pwm_in = 1'b1;
    cyc(1100);
    chk("t4_notyet", 32'(bus.signal_lost), 0);
    cyc(200);
    chk("t4_lost",   32'(bus.signal_lost), 1);
    chk("t4_onehot", 32'(bus.pos_onehot), 0);
    chk("t4_code",   32'(bus.pos_code), 32'h33);
    chk("t4_state",  32'(dut.state), 32'(ST_IDLE));
    bus.pwm_in = 1'b0;
    cyc(100);
    chk("t4_nomeas", 32'(n_meas), 32'(em));
    pulse(20, 1000);
    em++; ep++;
    chk("t4_code2",  32'(bus.pos_code), 32'h34);
    chk("t4_oh2",    32'(bus.pos_onehot), 32'b1000);
    chk("t4_clear",  32'(bus.signal_lost), 0);

    // 2-cycle low glitch inside a 90-cycle high
    bus.pwm_in = 1'b1; cyc(40);
    bus.pwm_in = 1'b0; cyc(2);
    bus.pwm_in = 1'b1; cyc(48);
    bus.pwm_in = 1'b0; cyc(910);
`ifdef PWM_GLITCH_FILTER_EN
    em++; ep++;
    chk("t5_code",  32'(bus.pos_code), 32'h32);
    chk("t5_width", 32'(bus.width), 90);
`else
    em += 2; ee += 2;
    chk("t5_code",  32'(bus.pos_code), 32'h34);
    chk("t5_width", 32'(bus.width), 48);
`endif
    chk("t5_err",  32'(n_err), 32'(ee));
    chk("t5_meas", 32'(n_meas), 32'(em));

    // reset mid-high, release while still high
    bus.pwm_in = 1'b1;
    cyc(50);
    rst_n = 1'b0;
    cyc(2);
    chk("t6_width",  32'(bus.width), 0);
    chk("t6_code",   32'(bus.pos_code), 0);
    chk("t6_period", 32'(bus.period), 0);
    rst_n = 1'b1;
    cyc(60);
    bus.pwm_in = 1'b0;
    cyc(500);
    chk("t6_nomeas", 32'(n_meas), 32'(em));
    chk("t6_w0",     32'(bus.width), 0);
    chk("t6_state",  32'(dut.state), 32'(ST_WAIT_R));
    pulse(55, 1000);
    em++; ep++;
    chk("t6_code2",  32'(bus.pos_code), 32'h33);
    chk("t6_width2", 32'(bus.width), 55);
    chk("t6_meas2",  32'(n_meas), 32'(em));
    chk("t6_pos",    32'(n_pos), 32'(ep));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
